// File: rtl/speed_scheduler.sv
// Game-speed scheduler: ramps the game-clock delay limit from LOWER_LIM down to
// UPPER_LIM, with collision penalties, pause/resume and abort.
module speed_scheduler #(
  parameter logic [29:0] LOWER_LIM    = 30'd555555,
  parameter logic [29:0] UPPER_LIM    = 30'd100000,
  parameter logic [29:0] DECREMENT    = 30'd1,
  parameter logic [29:0] PENALTY_STEP = 30'd50000,
  parameter logic [7:0]  PENALTY_HOLD = 8'd16
) (
  input  logic        delay_slow_clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        start,
  input  logic        stop,
  input  logic        pause,
  input  logic        hit,
  output logic [29:0] delay_lim,
  output logic        at_top_speed,
  output logic        hit_ack,
  output logic [2:0]  state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RAMP    = 3'd1;
  localparam logic [2:0] S_CRUISE  = 3'd2;
  localparam logic [2:0] S_PENALTY = 3'd3;
  localparam logic [2:0] S_PAUSED  = 3'd4;

  logic [2:0]  r_state, r_saved, w_state_next, w_saved_next;
  logic [29:0] r_delay, w_delay_next;
  logic [7:0]  r_hold, w_hold_next;
  logic        r_top, r_ack, w_ack_next;

  logic [30:0] w_sum;
  logic [29:0] w_pen_delay, w_ramp_delay;
  logic        w_ramp_room, w_active, w_pause_take, w_hit_take;

  // 31-bit sum so a large delay plus penalty cannot wrap before saturation
  assign w_sum        = {1'b0, r_delay} + {1'b0, PENALTY_STEP};
  assign w_pen_delay  = (w_sum > {1'b0, LOWER_LIM}) ? LOWER_LIM : w_sum[29:0];
  assign w_ramp_room  = {1'b0, r_delay} > ({1'b0, UPPER_LIM} + {1'b0, DECREMENT});
  assign w_ramp_delay = w_ramp_room ? (r_delay - DECREMENT) : UPPER_LIM;

  assign w_active     = (r_state == S_RAMP) || (r_state == S_CRUISE) || (r_state == S_PENALTY);
  assign w_pause_take = enable && !stop && pause && w_active;
  assign w_hit_take   = enable && !stop && !pause && hit &&
                        ((r_state == S_RAMP) || (r_state == S_CRUISE));

  always_ff @(posedge delay_slow_clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_saved <= S_IDLE;
      r_delay <= LOWER_LIM;
      r_hold  <= 8'd0;
      r_ack   <= 1'b0;
      r_top   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_saved <= w_saved_next;
      r_delay <= w_delay_next;
      r_hold  <= w_hold_next;
      r_ack   <= w_ack_next;
      r_top   <= (w_delay_next == UPPER_LIM);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_saved_next = r_saved;
    if (enable) begin
      if (stop) begin
        w_state_next = S_IDLE;
        w_saved_next = S_IDLE;
      end else if (w_pause_take) begin
        w_state_next = S_PAUSED;
        w_saved_next = r_state;
      end else if (w_hit_take) begin
        w_state_next = S_PENALTY;
      end else begin
        case (r_state)
          S_IDLE:    if (start) w_state_next = S_RAMP;
          S_RAMP:    if (!w_ramp_room) w_state_next = S_CRUISE;
          S_CRUISE:  w_state_next = S_CRUISE;
          S_PENALTY: if (r_hold == 8'd0) w_state_next = S_RAMP;
          S_PAUSED:  if (!pause) w_state_next = r_saved;
          default:   w_state_next = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    w_delay_next = r_delay;
    w_hold_next  = r_hold;
    w_ack_next   = 1'b0;
    if (enable) begin
      if (stop) begin
        w_delay_next = LOWER_LIM;
        w_hold_next  = 8'd0;
      end else if (w_hit_take) begin
        w_delay_next = w_pen_delay;
        w_hold_next  = PENALTY_HOLD - 8'd1;
        w_ack_next   = 1'b1;
      end else if (!w_pause_take) begin
        case (r_state)
          S_IDLE:    w_delay_next = LOWER_LIM;
          S_RAMP:    w_delay_next = w_ramp_delay;
          S_CRUISE:  w_delay_next = UPPER_LIM;
          S_PENALTY: if (r_hold != 8'd0) w_hold_next = r_hold - 8'd1;
          S_PAUSED:  w_hold_next = r_hold;
          default: begin
            w_delay_next = LOWER_LIM;
            w_hold_next  = 8'd0;
          end
        endcase
      end
    end
  end

  assign delay_lim    = r_delay;
  assign at_top_speed = r_top;
  assign hit_ack      = r_ack;
  assign state        = r_state;

endmodule

// File: tb/tb_speed_scheduler.sv
// Scoreboard bench for speed_scheduler: directed per-cycle vectors push expected
// outputs; a monitor pops one entry after every clock edge and compares.
module tb_speed_scheduler;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        pause = 1'b0;
  logic        hit = 1'b0;
  logic [29:0] delay_lim;
  logic        at_top_speed;
  logic        hit_ack;
  logic [2:0]  state;

  typedef struct {
    int          id;
    logic [2:0]  st;
    logic [29:0] dl;
    logic        top;
    logic        ack;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_push = 0;

  speed_scheduler #(
    .LOWER_LIM   (30'd20),
    .UPPER_LIM   (30'd10),
    .DECREMENT   (30'd3),
    .PENALTY_STEP(30'd8),
    .PENALTY_HOLD(8'd4)
  ) dut (
    .delay_slow_clk(clk),
    .resetn        (resetn),
    .enable        (enable),
    .start         (start),
    .stop          (stop),
    .pause         (pause),
    .hit           (hit),
    .delay_lim     (delay_lim),
    .at_top_speed  (at_top_speed),
    .hit_ack       (hit_ack),
    .state         (state)
  );

  always #5 clk = ~clk;

  // Apply inputs for one clock and queue the outputs expected after that edge.
  task automatic drive(input logic rn, input logic en, input logic st_i, input logic sp_i,
                       input logic pa_i, input logic hi_i, input logic [2:0] e_st,
                       input int e_dl, input logic e_top, input logic e_ack);
    exp_t e;
    @(negedge clk);
    resetn = rn;
    enable = en;
    start  = st_i;
    stop   = sp_i;
    pause  = pa_i;
    hit    = hi_i;
    e.id   = n_push;
    e.st   = e_st;
    e.dl   = 30'(e_dl);
    e.top  = e_top;
    e.ack  = e_ack;
    q.push_back(e);
    n_push++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        $display("vec %0d: state=%0d delay_lim=%0d top=%0d ack=%0d", e.id, state, delay_lim,
                 at_top_speed, hit_ack);
        if ({state, delay_lim, at_top_speed, hit_ack} !== {e.st, e.dl, e.top, e.ack}) begin
          n_bad++;
          $display("FAIL vec%0d: got state=%0d dl=%0d top=%0d ack=%0d, want state=%0d dl=%0d top=%0d ack=%0d",
                   e.id, state, delay_lim, at_top_speed, hit_ack, e.st, e.dl, e.top, e.ack);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    // reset state
    drive(0,0,0,0,0,0, 0,20,0,0);
    drive(0,1,1,0,0,1, 0,20,0,0);
    drive(1,1,0,0,0,0, 0,20,0,0);
    // ramp 20,17,14,11,10 then cruise
    drive(1,1,1,0,0,0, 1,20,0,0);
    drive(1,1,0,0,0,0, 1,17,0,0);
    drive(1,1,0,0,0,0, 1,14,0,0);
    drive(1,1,0,0,0,0, 1,11,0,0);
    drive(1,1,0,0,0,0, 2,10,1,0);
    drive(1,1,0,0,0,0, 2,10,1,0);
    // hit in cruise: 10+8=18, four penalty clocks, then ramp 15,12,10
    drive(1,1,0,0,0,1, 3,18,0,1);
    drive(1,1,0,0,0,0, 3,18,0,0);
    drive(1,1,0,0,0,0, 3,18,0,0);
    drive(1,1,0,0,0,0, 3,18,0,0);
    drive(1,1,0,0,0,0, 1,18,0,0);
    drive(1,1,0,0,0,0, 1,15,0,0);
    drive(1,1,0,0,0,0, 1,12,0,0);
    drive(1,1,0,0,0,0, 2,10,1,0);
    // saturation: 17+8=25 clamps to 20; second hit in penalty ignored
    drive(1,1,0,1,0,0, 0,20,0,0);
    drive(1,1,1,0,0,0, 1,20,0,0);
    drive(1,1,0,0,0,0, 1,17,0,0);
    drive(1,1,0,0,0,1, 3,20,0,1);
    drive(1,1,0,0,0,1, 3,20,0,0);
    // pause for 5 clocks with hold count frozen at 2; it then counts 2,1,0
    drive(1,1,0,0,1,0, 4,20,0,0);
    drive(1,1,0,0,1,0, 4,20,0,0);
    drive(1,1,0,0,1,1, 4,20,0,0);
    drive(1,1,0,0,1,0, 4,20,0,0);
    drive(1,1,0,0,1,0, 4,20,0,0);
    drive(1,1,0,0,0,0, 3,20,0,0);
    drive(1,1,0,0,0,0, 3,20,0,0);
    drive(1,1,0,0,0,0, 3,20,0,0);
    drive(1,1,0,0,0,0, 1,20,0,0);
    drive(1,1,0,0,0,0, 1,17,0,0);
    // stop beats pause and hit
    drive(1,1,0,1,1,1, 0,20,0,0);
    // enable low in ramp freezes everything and ignores inputs
    drive(1,1,1,0,0,0, 1,20,0,0);
    drive(1,1,0,0,0,0, 1,17,0,0);
    drive(1,0,0,0,0,1, 1,17,0,0);
    drive(1,0,0,1,0,0, 1,17,0,0);
    drive(1,0,0,0,1,0, 1,17,0,0);
    drive(1,1,0,0,0,0, 1,14,0,0);
    // reset while paused out of penalty
    drive(1,1,0,0,0,1, 3,20,0,1);
    drive(1,1,0,0,1,0, 4,20,0,0);
    drive(0,1,0,0,1,0, 0,20,0,0);
    drive(1,1,0,0,0,0, 0,20,0,0);
    drive(1,1,0,0,1,1, 0,20,0,0);
    drive(1,1,0,0,0,0, 0,20,0,0);
    // reset mid-ramp overrides start
    drive(1,1,1,0,0,0, 1,20,0,0);
    drive(1,1,0,0,0,0, 1,17,0,0);
    drive(0,1,1,0,0,0, 0,20,0,0);
    drive(1,1,0,0,0,1, 0,20,0,0);
    @(negedge clk);
    resetn = 1'b1;
    enable = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    pause  = 1'b0;
    hit    = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected vectors never checked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/speed_scheduler.md
SPEED_SCHEDULER -- requirements
Module: speed_scheduler

Interface
REQ-001 The block SHALL have parameter LOWER_LIM, default 30'd555555: slowest (largest) delay limit.
REQ-002 The block SHALL have parameter UPPER_LIM, default 30'd100000: fastest (smallest) delay limit; UPPER_LIM < LOWER_LIM.
REQ-003 The block SHALL have parameter DECREMENT, default 30'd1: ramp step per clock.
REQ-004 The block SHALL have parameter PENALTY_STEP, default 30'd50000: delay added on a hit.
REQ-005 The block SHALL have parameter PENALTY_HOLD, default 8'd16: clocks spent in PENALTY, range 1..255.
REQ-006 The block SHALL have port delay_slow_clk  input  1  clock; all state changes on its rising edge.
REQ-007 The block SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-008 The block SHALL have port enable  input  1  global run enable; low freezes all state.
REQ-009 The block SHALL have port start  input  1  pulse; begins ramp from IDLE.
REQ-010 The block SHALL have port stop  input  1  pulse; abort to IDLE.
REQ-011 The block SHALL have port pause  input  1  level; freezes speed while high.
REQ-012 The block SHALL have port hit  input  1  pulse; collision penalty request.
REQ-013 The block SHALL have port delay_lim  output  30  delay limit driven to the game-clock delay counter.
REQ-014 The block SHALL have port at_top_speed  output  1  high iff delay_lim == UPPER_LIM.
REQ-015 The block SHALL have port hit_ack  output  1  one-cycle pulse when a hit is accepted.
REQ-016 The block SHALL have port state  output  3  IDLE=0, RAMP=1, CRUISE=2, PENALTY=3, PAUSED=4.

Function
REQ-017 All outputs SHALL be registered; every transition below takes effect on the next clock edge.
REQ-018 While enable=0 (and resetn=1), all registers SHALL hold; start, stop, hit and pause are ignored; hit_ack=0.
REQ-019 Input priority SHALL be: stop > pause > hit > start/normal progression.
REQ-020 stop in any state SHALL go to IDLE with delay_lim=LOWER_LIM, hold count 0, and no hit_ack.
REQ-021 In IDLE, delay_lim SHALL equal LOWER_LIM; start SHALL go to RAMP; pause and hit are ignored.
REQ-022 In RAMP, each clock with delay_lim - DECREMENT > UPPER_LIM SHALL subtract DECREMENT; otherwise delay_lim SHALL load UPPER_LIM exactly (no undershoot) and go to CRUISE.
REQ-023 In CRUISE, delay_lim SHALL hold UPPER_LIM.
REQ-024 A hit in RAMP or CRUISE SHALL set delay_lim = min(delay_lim + PENALTY_STEP, LOWER_LIM) using a 31-bit sum, load the hold count with PENALTY_HOLD-1, pulse hit_ack, and go to PENALTY.
REQ-025 In PENALTY, delay_lim SHALL hold; the hold count decrements each clock; at count 0 the block SHALL go to RAMP.
REQ-026 A hit in PENALTY, PAUSED or IDLE SHALL be ignored (no ack, no delay change).
REQ-027 pause high in RAMP, CRUISE or PENALTY SHALL go to PAUSED, saving the source state; delay_lim and hold count SHALL freeze.
REQ-028 In PAUSED, pause low SHALL return to the saved state, which resumes from the frozen values.
REQ-029 at_top_speed SHALL be recomputed from the next delay_lim value, so it is coincident with delay_lim.

Reset
REQ-030 resetn=0 at a clock edge SHALL force state=IDLE, delay_lim=LOWER_LIM, at_top_speed=0, hit_ack=0, hold count 0, and saved state=IDLE, overriding all inputs, including mid-RAMP, mid-PENALTY and while PAUSED.

Verification
REQ-031 Bench SHALL use LOWER_LIM=20, UPPER_LIM=10, DECREMENT=3, PENALTY_STEP=8, PENALTY_HOLD=4 and cover the following scenarios:
REQ-032 Ramp: reset, then a start pulse -> delay_lim 20,17,14,11,10; state 1 then 2 on the cycle that loads 10; at_top_speed=1 on that cycle.
REQ-033 Penalty: hit in CRUISE -> delay_lim=18, hit_ack high for 1 cycle, state=3 for 4 clocks; then RAMP 15,12,10 back to CRUISE.
REQ-034 Saturation: hit when delay_lim=17 -> delay_lim=20, not 25; a second hit during PENALTY -> no ack, delay stays 20.
REQ-035 Pause: pause high on the 2nd PENALTY clock for 5 clocks -> state=4 and delay frozen; on release PENALTY resumes with exactly 2 remaining clocks.
REQ-036 Priority/enable: stop, hit and pause asserted in the same cycle in RAMP -> IDLE, delay_lim=20, hit_ack=0; with enable=0 in RAMP for 3 clocks -> delay_lim unchanged.
REQ-037 Reset mid-op: resetn=0 during PAUSED-from-PENALTY -> next edge state=0, delay_lim=20, and pause release does not leave IDLE.
